// File: rtl/cam_pixel_packer.sv
// Camera pixel packer: converts a pixel-rate camera stream into
// AXI_DATA_WIDTH-bit words and issues burst requests for them. A partial
// word at a line end is padded with zero lanes. A request that is still
// pending when another burst completes makes the new burst get dropped and
// raises a sticky overflow flag.
module cam_pixel_packer #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int PIX_MODE       = 0,
    parameter int BURST_LEN      = 16
) (
    input  logic                      cam_pclk,
    input  logic                      cam_rst,
    input  logic                      cam_vsync,
    input  logic                      cam_href,
    input  logic [23:0]               cam_data,
    input  logic                      cam_data_valid,
    output logic [AXI_DATA_WIDTH-1:0] word_data,
    output logic                      word_valid,
    output logic                      word_last,
    output logic                      burst_valid,
    output logic [8:0]                burst_len,
    input  logic                      burst_ready,
    output logic                      frame_start,
    output logic                      overflow
);

    localparam int AW  = AXI_DATA_WIDTH;
    localparam int LW  = (PIX_MODE == 1) ? 16 : 32;
    localparam int PPW = AW / LW;
    localparam int PCW = $clog2(PPW + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_REQ} state_t;

    // Convert one RGB888 pixel into a lane of the selected format.
    function automatic logic [LW-1:0] make_lane(input logic [23:0] d);
        if (PIX_MODE == 1) begin
            return LW'({d[23:19], d[15:10], d[7:3]});
        end else begin
            return LW'({8'hff, d});
        end
    endfunction

    // Pad a partial word: shift the k pending lanes up so zero lanes fill the LSBs.
    function automatic logic [AW-1:0] flush_word(input logic [AW-1:0] b,
                                                 input logic [PCW-1:0] k);
        return b << (LW * (PPW - int'(k)));
    endfunction

    state_t              state_r, state_nxt;
    logic                href_d1_r, vsync_d1_r;
    logic [AW-1:0]       buf_r;
    logic [PCW-1:0]      pix_cnt_r;
    logic [8:0]          word_cnt_r, pend_len_r;
    logic                done_r;

    logic                pix_in_s, line_end_s, vsync_rise_s;
    logic                hs_s, accept_s, ovf_set_s;
    logic [LW-1:0]       lane_s;
    logic [AW-1:0]       shifted_s;
    logic [8:0]          word_inc_s;
    logic                burst_valid_nxt_s, overflow_nxt_s;
    logic [8:0]          burst_len_nxt_s;
    logic                unused_bits_s;

    assign pix_in_s     = cam_href & cam_data_valid;
    assign line_end_s   = href_d1_r & ~cam_href;
    assign vsync_rise_s = cam_vsync & ~vsync_d1_r;
    assign hs_s         = burst_valid & burst_ready;
    assign accept_s     = done_r & ~(burst_valid & ~burst_ready);
    assign ovf_set_s    = done_r & burst_valid & ~burst_ready;
    assign lane_s       = make_lane(cam_data);
    assign shifted_s    = {buf_r[AW-LW-1:0], lane_s};
    assign word_inc_s   = word_cnt_r + 9'd1;
    assign unused_bits_s = ^cam_data;

    // Edge-detect history for href and vsync.
    always_ff @(posedge cam_pclk or posedge cam_rst) begin
        if (cam_rst) begin
            href_d1_r  <= 1'b0;
            vsync_d1_r <= 1'b0;
        end else begin
            href_d1_r  <= cam_href;
            vsync_d1_r <= cam_vsync;
        end
    end

    // Packing datapath: lane shifting, word emission, line-end flush and word counting.
    always_ff @(posedge cam_pclk or posedge cam_rst) begin
        if (cam_rst) begin
            buf_r       <= '0;
            pix_cnt_r   <= '0;
            word_cnt_r  <= 9'd0;
            pend_len_r  <= 9'd0;
            done_r      <= 1'b0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            word_last   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            word_valid  <= 1'b0;
            word_last   <= 1'b0;
            done_r      <= 1'b0;
            frame_start <= vsync_rise_s;
            if (vsync_rise_s) begin
                buf_r      <= '0;
                pix_cnt_r  <= '0;
                word_cnt_r <= 9'd0;
            end else if (pix_in_s) begin
                if (pix_cnt_r == PCW'(PPW - 1)) begin
                    word_data  <= shifted_s;
                    word_valid <= 1'b1;
                    buf_r      <= '0;
                    pix_cnt_r  <= '0;
                    if (word_inc_s == 9'(BURST_LEN)) begin
                        word_last  <= 1'b1;
                        done_r     <= 1'b1;
                        pend_len_r <= word_inc_s;
                        word_cnt_r <= 9'd0;
                    end else begin
                        word_cnt_r <= word_inc_s;
                    end
                end else begin
                    buf_r     <= shifted_s;
                    pix_cnt_r <= pix_cnt_r + PCW'(1);
                end
            end else if (line_end_s) begin
                if (pix_cnt_r != PCW'(0)) begin
                    word_data  <= flush_word(buf_r, pix_cnt_r);
                    word_valid <= 1'b1;
                    word_last  <= 1'b1;
                    done_r     <= 1'b1;
                    pend_len_r <= word_inc_s;
                    word_cnt_r <= 9'd0;
                    buf_r      <= '0;
                    pix_cnt_r  <= '0;
                end else if (word_cnt_r != 9'd0) begin
                    done_r     <= 1'b1;
                    pend_len_r <= word_cnt_r;
                    word_cnt_r <= 9'd0;
                end else begin
                    word_cnt_r <= word_cnt_r;
                end
            end else begin
                buf_r <= buf_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge cam_pclk or posedge cam_rst) begin
        if (cam_rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next-state logic; an accepted burst completion always moves to REQ.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt = S_REQ;
                end else if (pix_in_s) begin
                    state_nxt = S_ACCUM;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (accept_s) begin
                    state_nxt = S_REQ;
                end else if (line_end_s && (pix_cnt_r != PCW'(0))) begin
                    state_nxt = S_FLUSH;
                end else begin
                    state_nxt = S_ACCUM;
                end
            end
            S_FLUSH: begin
                if (accept_s) begin
                    state_nxt = S_REQ;
                end else begin
                    state_nxt = S_ACCUM;
                end
            end
            S_REQ: begin
                if (hs_s && !done_r) begin
                    state_nxt = cam_href ? S_ACCUM : S_IDLE;
                end else begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode: next values of the burst request outputs and overflow flag.
    always_comb begin
        burst_valid_nxt_s = (state_nxt == S_REQ);
        burst_len_nxt_s   = burst_len;
        overflow_nxt_s    = overflow;
        if (accept_s) begin
            burst_len_nxt_s = pend_len_r;
        end else begin
            burst_len_nxt_s = burst_len;
        end
        if (vsync_rise_s) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow | ovf_set_s;
        end
    end

    // Register the burst request outputs and the overflow flag.
    always_ff @(posedge cam_pclk or posedge cam_rst) begin
        if (cam_rst) begin
            burst_valid <= 1'b0;
            burst_len   <= 9'd0;
            overflow    <= 1'b0;
        end else begin
            burst_valid <= burst_valid_nxt_s;
            burst_len   <= burst_len_nxt_s;
            overflow    <= overflow_nxt_s;
        end
    end

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed self-checking bench for cam_pixel_packer (128-bit words, BURST_LEN 4),
// with one RGB888 instance and one RGB565 instance sharing the same stimulus.
module tb_cam_pixel_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         vsync, href, dv, ready;
    logic [23:0]  data;

    logic [127:0] wd0, wd1;
    logic         wv0, wl0, bv0, fs0, ov0;
    logic         wv1, wl1, bv1, fs1, ov1;
    logic [8:0]   bl0, bl1;

    int vectors     = 0;
    int miscompares = 0;
    int wv_cnt      = 0;

    cam_pixel_packer #(.AXI_DATA_WIDTH(128), .PIX_MODE(0), .BURST_LEN(4)) dut0 (
        .cam_pclk(clk), .cam_rst(rst), .cam_vsync(vsync), .cam_href(href),
        .cam_data(data), .cam_data_valid(dv), .word_data(wd0), .word_valid(wv0),
        .word_last(wl0), .burst_valid(bv0), .burst_len(bl0), .burst_ready(ready),
        .frame_start(fs0), .overflow(ov0));

    cam_pixel_packer #(.AXI_DATA_WIDTH(128), .PIX_MODE(1), .BURST_LEN(4)) dut1 (
        .cam_pclk(clk), .cam_rst(rst), .cam_vsync(vsync), .cam_href(href),
        .cam_data(data), .cam_data_valid(dv), .word_data(wd1), .word_valid(wv1),
        .word_last(wl1), .burst_valid(bv1), .burst_len(bl1), .burst_ready(ready),
        .frame_start(fs1), .overflow(ov1));

    always #5 clk = ~clk;

    // Count words emitted by the RGB888 instance.
    always @(posedge clk) begin
        if (wv0 === 1'b1) wv_cnt <= wv_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic [23:0] d);
        href = 1'b1;
        dv   = 1'b1;
        data = d;
        tick();
        dv   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; vsync = 1'b0; href = 1'b0; dv = 1'b0; ready = 1'b1; data = 24'h0;
        tick(); tick();
        vectors++; if (wd0 !== 128'h0) begin miscompares++; $display("FAIL reset_wd: got %h want 0", wd0); end
        vectors++; if (wv0 !== 1'b0) begin miscompares++; $display("FAIL reset_wv: got %b want 0", wv0); end
        vectors++; if (wl0 !== 1'b0) begin miscompares++; $display("FAIL reset_wl: got %b want 0", wl0); end
        vectors++; if (bv0 !== 1'b0) begin miscompares++; $display("FAIL reset_bv: got %b want 0", bv0); end
        vectors++; if (bl0 !== 9'd0) begin miscompares++; $display("FAIL reset_bl: got %0d want 0", bl0); end
        vectors++; if (fs0 !== 1'b0 || ov0 !== 1'b0) begin miscompares++; $display("FAIL reset_fs_ov: got %b%b want 00", fs0, ov0); end
        vectors++; if (wd1 !== 128'h0) begin miscompares++; $display("FAIL reset_wd1: got %h want 0", wd1); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_word;
        for (int i = 1; i <= 4; i++) send_px(24'(i));
        vectors++; if (wv0 !== 1'b1) begin miscompares++; $display("FAIL single_wv: got %b want 1", wv0); end
        vectors++; if (wd0 !== 128'hff000001_ff000002_ff000003_ff000004) begin miscompares++; $display("FAIL single_wd: got %h want ff000001ff000002ff000003ff000004", wd0); end
        vectors++; if (wl0 !== 1'b0) begin miscompares++; $display("FAIL single_wl: got %b want 0", wl0); end
        tick();
        vectors++; if (wv0 !== 1'b0) begin miscompares++; $display("FAIL single_wv_pulse: got %b want 0", wv0); end
        vectors++; if (wd0 !== 128'hff000001_ff000002_ff000003_ff000004) begin miscompares++; $display("FAIL single_hold: got %h", wd0); end
    endtask

    task automatic test_burst;
        int base;
        base = wv_cnt;
        for (int i = 5; i <= 16; i++) send_px(24'(i));
        vectors++; if (wv0 !== 1'b1 || wl0 !== 1'b1) begin miscompares++; $display("FAIL burst_last: got wv=%b wl=%b want 1 1", wv0, wl0); end
        vectors++; if (wd0 !== 128'hff00000d_ff00000e_ff00000f_ff000010) begin miscompares++; $display("FAIL burst_wd: got %h", wd0); end
        vectors++; if (bv0 !== 1'b0) begin miscompares++; $display("FAIL burst_bv_early: got %b want 0", bv0); end
        tick();
        vectors++; if (bv0 !== 1'b1 || bl0 !== 9'd4) begin miscompares++; $display("FAIL burst_req: got bv=%b len=%0d want 1 4", bv0, bl0); end
        vectors++; if (wv_cnt - base !== 3) begin miscompares++; $display("FAIL burst_words: got %0d want 3", wv_cnt - base); end
        tick();
        vectors++; if (bv0 !== 1'b0) begin miscompares++; $display("FAIL burst_clear: got %b want 0", bv0); end
    endtask

    task automatic test_idle_line_end;
        href = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (wv0 !== 1'b0 || bv0 !== 1'b0 || wl0 !== 1'b0) begin miscompares++; $display("FAIL idle_end: got wv=%b bv=%b wl=%b want 000", wv0, bv0, wl0); end
        end
    endtask

    task automatic test_partial_line;
        for (int i = 1; i <= 6; i++) send_px(24'(i));
        href = 1'b0;
        tick();
        vectors++; if (wv0 !== 1'b1 || wl0 !== 1'b1) begin miscompares++; $display("FAIL flush_flags: got wv=%b wl=%b want 1 1", wv0, wl0); end
        vectors++; if (wd0 !== 128'hff000005_ff000006_00000000_00000000) begin miscompares++; $display("FAIL flush_wd: got %h", wd0); end
        tick();
        vectors++; if (bv0 !== 1'b1 || bl0 !== 9'd2) begin miscompares++; $display("FAIL flush_req: got bv=%b len=%0d want 1 2", bv0, bl0); end
        tick();
        vectors++; if (bv0 !== 1'b0) begin miscompares++; $display("FAIL flush_clear: got %b want 0", bv0); end
        tick();
    endtask

    task automatic test_overflow;
        ready = 1'b0;
        for (int i = 1; i <= 16; i++) send_px(24'(i));
        tick();
        vectors++; if (bv0 !== 1'b1 || bl0 !== 9'd4) begin miscompares++; $display("FAIL ovf_first_req: got bv=%b len=%0d want 1 4", bv0, bl0); end
        for (int i = 17; i <= 22; i++) send_px(24'(i));
        href = 1'b0;
        tick();
        tick();
        vectors++; if (ov0 !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1", ov0); end
        vectors++; if (bv0 !== 1'b1 || bl0 !== 9'd4) begin miscompares++; $display("FAIL ovf_hold: got bv=%b len=%0d want 1 4", bv0, bl0); end
        vsync = 1'b1;
        tick();
        vectors++; if (fs0 !== 1'b1) begin miscompares++; $display("FAIL vsync_fs: got %b want 1", fs0); end
        vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL vsync_ovf_clr: got %b want 0", ov0); end
        vectors++; if (bv0 !== 1'b1) begin miscompares++; $display("FAIL vsync_keep_bv: got %b want 1", bv0); end
        tick();
        vectors++; if (fs0 !== 1'b0) begin miscompares++; $display("FAIL vsync_fs_pulse: got %b want 0", fs0); end
        vsync = 1'b0;
        ready = 1'b1;
        tick();
        vectors++; if (bv0 !== 1'b0) begin miscompares++; $display("FAIL ovf_hs_clear: got %b want 0", bv0); end
    endtask

    task automatic test_rgb565;
        send_px(24'h123456);
        for (int i = 0; i < 7; i++) send_px(24'h000000);
        vectors++; if (wv1 !== 1'b1) begin miscompares++; $display("FAIL rgb565_wv: got %b want 1", wv1); end
        vectors++; if (wd1 !== 128'h11aa0000_00000000_00000000_00000000) begin miscompares++; $display("FAIL rgb565_order: got %h", wd1); end
        for (int i = 0; i < 8; i++) send_px(24'hF8FCF8);
        vectors++; if (wv1 !== 1'b1 || wd1 !== {8{16'hFFFF}}) begin miscompares++; $display("FAIL rgb565_ones: got wv=%b wd=%h", wv1, wd1); end
        href = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_reset_midline;
        ready = 1'b0;
        for (int i = 1; i <= 16; i++) send_px(24'h100 + 24'(i));
        tick();
        vectors++; if (bv0 !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_bv: got %b want 1", bv0); end
        send_px(24'h0000ee);
        send_px(24'h0000ef);
        rst = 1'b1;
        #1;
        vectors++; if (bv0 !== 1'b0 || bl0 !== 9'd0) begin miscompares++; $display("FAIL midrst_burst: got bv=%b len=%0d want 0 0", bv0, bl0); end
        vectors++; if (wd0 !== 128'h0 || wv0 !== 1'b0 || wl0 !== 1'b0) begin miscompares++; $display("FAIL midrst_word: got wd=%h wv=%b wl=%b", wd0, wv0, wl0); end
        #1;
        rst = 1'b0;
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) send_px(24'ha0 + 24'(i));
        vectors++; if (wv0 !== 1'b1 || wd0 !== 128'hff0000a1_ff0000a2_ff0000a3_ff0000a4) begin miscompares++; $display("FAIL midrst_lane0: got wv=%b wd=%h", wv0, wd0); end
        vectors++; if (bv0 !== 1'b0) begin miscompares++; $display("FAIL midrst_no_req: got %b want 0", bv0); end
        href = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst();
        test_idle_line_end();
        test_partial_line();
        test_overflow();
        test_rgb565();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_pixel_packer.md
CAM_PIXEL_PACKER -- requirements
Module: cam_pixel_packer

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 128, output word width; legal values 64, 128, 256.
REQ-002 SHALL have parameter PIX_MODE, default 0, pixel format: 0 = RGB888 as 32-bit lane {8'hff, pixel}; 1 = RGB565 as 16-bit lane {d[23:19], d[15:10], d[7:3]}.
REQ-003 SHALL have parameter BURST_LEN, default 16, words per full burst; legal range 1..256.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: cam_pclk  input  1  pixel clock, sole clock; cam_rst  input  1  asynchronous active-high reset.
REQ-005 cam_vsync  input  1  frame sync; a rising edge starts a new frame.
REQ-006 cam_href  input  1  line active; a falling edge ends a line.
REQ-007 cam_data  input  24  pixel, RGB888 in [23:0].
REQ-008 cam_data_valid  input  1  pixel strobe; counted only while cam_href = 1.
REQ-009 word_data  output  AXI_DATA_WIDTH  packed word.
REQ-010 word_valid  output  1  one-cycle strobe qualifying word_data.
REQ-011 word_last  output  1  high with word_valid on the final word of a burst.
REQ-012 burst_valid  output  1  burst request.
REQ-013 burst_len  output  9  word count of the requested burst, 1..BURST_LEN.
REQ-014 burst_ready  input  1  burst request accepted when high with burst_valid.
REQ-015 frame_start  output  1  one-cycle pulse on a cam_vsync rising edge.
REQ-016 overflow  output  1  sticky flag: a burst was lost.

Function
REQ-017 Lane width SHALL be LW = 32 (PIX_MODE 0) or 16 (PIX_MODE 1); pixels per word SHALL be PPW = AXI_DATA_WIDTH / LW.
REQ-018 Packing SHALL shift each new lane into the LSBs, moving older lanes up, so the oldest pixel sits in the MSB lane.
REQ-019 word_valid SHALL assert for one cycle, the cycle after the edge that captured the PPW-th pixel; word_data SHALL hold until the next word_valid.
REQ-020 cam_href SHALL be registered once; a line end SHALL be detected as href_d1 = 1 and cam_href = 0.
REQ-021 At a line end with 0 < k < PPW pending pixels, the block SHALL flush in the next cycle: shift in PPW-k all-zero lanes and pulse word_valid.
REQ-022 The word counter SHALL increment on every word_valid.
REQ-023 When the word counter reaches BURST_LEN, or a line end (after any flush) leaves it nonzero, the block SHALL assert word_last with that word_valid and set burst_valid in the next cycle.
REQ-024 With burst_valid set, burst_len SHALL equal the captured word count, and the word counter SHALL restart from 0.
REQ-025 burst_valid and burst_len SHALL hold stable until burst_valid & burst_ready; burst_valid SHALL clear the cycle after the handshake.
REQ-026 FSM states SHALL be IDLE, ACCUM, FLUSH, REQ:
 - IDLE -> ACCUM on the first valid pixel.
 - ACCUM -> FLUSH on a line end with a partial word pending.
 - ACCUM -> REQ on burst completion.
 - FLUSH -> REQ after the flush word.
 - REQ -> ACCUM (or IDLE if cam_href = 0) on the handshake.
 - Packing SHALL continue while in REQ.
REQ-027 If a new burst completes while the previous request is still pending, overflow SHALL set, the new burst SHALL be dropped, and burst_len SHALL be unchanged.
REQ-028 A handshake in the same cycle as a new burst completion SHALL NOT set overflow; the new request SHALL assert the next cycle.
REQ-029 On a cam_vsync rising edge the block SHALL:
 - pulse frame_start;
 - discard pending lanes and the word count;
 - clear overflow;
 - keep a pending burst_valid until its handshake.
REQ-030 A line end with no pending pixels and a zero word count SHALL produce no output activity.

Reset
REQ-031 While cam_rst = 1, all outputs, counters, the packing buffer and href_d1 SHALL be 0 and the FSM SHALL be IDLE, regardless of state at assertion.
REQ-032 After cam_rst deasserts, the first valid pixel SHALL start a new word in lane 0.

Verification (AXI_DATA_WIDTH = 128, BURST_LEN = 4 unless stated)
REQ-033 PIX_MODE 0, pixels 0x000001..0x000004 -> one word_valid, word_data = 0xff000001_ff000002_ff000003_ff000004.
REQ-034 16 pixels, burst_ready = 1 -> 4 word_valid, word_last on the 4th, burst_valid 1 cycle later with burst_len = 4, cleared the next cycle.
REQ-035 6-pixel line then href low -> word 2 = 0xff000005_ff000006_00000000_00000000, word_last = 1, burst_len = 2.
REQ-036 burst_ready = 0 across two completed bursts -> overflow = 1 and burst_len = 4 held; the next vsync rise clears overflow and pulses frame_start.
REQ-037 PIX_MODE 1, 8 pixels 0xF8FCF8 -> word_data = all ones (16'hFFFF x 8).
REQ-038 cam_rst pulsed mid-line with burst_valid = 1 -> all outputs 0 asynchronously; the next pixel lands in lane 0.
